rrarbiter_ctrl: RTL and testbench

Sequential round-robin arbiter that owns the rotating one-hot priority pointer and the grant for a shared downstream resource. Each cycle it picks a winner from `req` by circular search from the pointer, holds the grant across a multi-beat transfer, and advances the pointer one position past the winner on release. It sits between N requesters and a single downstream port.

---
 rtl/rrarbiter_ctrl.sv | 136 +++++++++++++
 tb/tb_rrarbiter_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rrarbiter_ctrl.sv
// Round-robin arbiter with a rotating one-hot priority pointer and a held grant
// for multi-beat transfers; release and re-grant happen on the same edge.
module rrarbiter_ctrl #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 16,
    localparam int unsigned IW      = $clog2(N),
    localparam int unsigned HW      = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          out_ready,
    input  logic          out_last,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic [N-1:0]  prio,
    output logic          timeout
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  prio_q, prio_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;
    logic          gnt_valid_q;
    logic [IW-1:0] gnt_idx_q;

    logic          rel_a, rel_b, rel_c;
    logic [N-1:0]  prio_rot;
    logic [N-1:0]  arb_req;
    logic [N-1:0]  winner_idle, winner_rel;

    // Circular search starting at the set bit of p, wrapping N-1 -> 0.
    function automatic logic [N-1:0] arb_pick(input logic [N-1:0] r, input logic [N-1:0] p);
        logic [N-1:0] pick;
        logic         found;
        int           base;
        int           j;
        pick  = '0;
        found = 1'b0;
        base  = 0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) base = i;
        end
        for (int k = 0; k < N; k++) begin
            j = (base + k) % N;
            if (!found && r[j]) begin
                pick[j] = 1'b1;
                found   = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IW-1:0] onehot_enc(input logic [N-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    always_comb begin
        rel_a    = out_ready && out_last;
        rel_b    = ~|(req & gnt_q);
        rel_c    = (hold_q == HW'(MAX_HOLD - 1));
        prio_rot = {gnt_q[N-2:0], gnt_q[N-1]};
        // Withdrawal masks the releaser; a simultaneous normal release does not.
        arb_req     = (rel_b && !rel_a) ? (req & ~gnt_q) : req;
        winner_idle = arb_pick(req, prio_q);
        winner_rel  = arb_pick(arb_req, prio_rot);
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        prio_d    = prio_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d   = winner_idle;
                    hold_d  = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (rel_a || rel_b || rel_c) begin
                    prio_d    = prio_rot;
                    timeout_d = !rel_a && !rel_b;
                    gnt_d     = winner_rel;
                    hold_d    = '0;
                    state_d   = (|winner_rel) ? StBusy : StIdle;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            prio_q      <= N'(1);
            hold_q      <= '0;
            timeout_q   <= 1'b0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            prio_q      <= prio_d;
            hold_q      <= hold_d;
            timeout_q   <= timeout_d;
            gnt_valid_q <= |gnt_d;
            gnt_idx_q   <= onehot_enc(gnt_d);
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign prio      = prio_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rrarbiter_ctrl.sv
// Scoreboard bench for rrarbiter_ctrl: a behavioural model predicts each cycle's
// registered outputs, queued at drive time and compared after the clock edge.
module tb_rrarbiter_ctrl;

    localparam int N    = 4;
    localparam int MAXH = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         out_ready;
    logic         out_last;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_idx;
    logic [N-1:0] prio;
    logic         timeout;

    rrarbiter_ctrl #(
        .N        (N),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .out_last  (out_last),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .prio      (prio),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] prio;
        logic [1:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model state: granted index (-1 none), pointer index, hold counter.
    bit m_busy;
    int m_g;
    int m_p;
    int m_hold;
    bit m_to;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int arb(input logic [3:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_g    = -1;
        m_p    = 0;
        m_hold = 0;
        m_to   = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input bit rdy, input bit lst);
        bit a, b, c;
        logic [3:0] rr;
        int w;
        m_to = 0;
        if (!m_busy) begin
            if (r != 0) begin
                m_g    = arb(r, m_p);
                m_hold = 0;
                m_busy = 1;
            end
        end else begin
            a = rdy && lst;
            b = !r[m_g];
            c = (m_hold == MAXH - 1);
            if (a || b || c) begin
                m_to = !a && !b;
                m_p  = (m_g + 1) % N;
                rr   = r;
                if (b && !a) rr[m_g] = 1'b0;
                w = arb(rr, m_p);
                if (w >= 0) begin
                    m_g    = w;
                    m_hold = 0;
                end else begin
                    m_g    = -1;
                    m_busy = 0;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input bit rdy, input bit lst);
        exp_t e;
        exp_t got;
        req       = r;
        out_ready = rdy;
        out_last  = lst;
        model_step(r, rdy, lst);
        e.gnt   = (m_g >= 0) ? 4'(1 << m_g) : 4'b0;
        e.prio  = 4'(1 << m_p);
        e.idx   = (m_g >= 0) ? 2'(m_g) : 2'd0;
        e.valid = (m_g >= 0);
        e.to    = m_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_eq("gnt", 32'(gnt), 32'(got.gnt));
        check_eq("prio", 32'(prio), 32'(got.prio));
        check_eq("gnt_idx", 32'(gnt_idx), 32'(got.idx));
        check_eq("gnt_valid", 32'(gnt_valid), 32'(got.valid));
        check_eq("timeout", 32'(timeout), 32'(got.to));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_gnt"}, 32'(gnt), 32'h0);
        check_eq({tag, "_valid"}, 32'(gnt_valid), 32'h0);
        check_eq({tag, "_idx"}, 32'(gnt_idx), 32'h0);
        check_eq({tag, "_prio"}, 32'(prio), 32'h1);
        check_eq({tag, "_timeout"}, 32'(timeout), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b0;
        out_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;

        // Full rotation with single-beat transfers, no idle cycles.
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);

        // Multi-beat hold; final beat coincides with hold limit, no timeout.
        step(4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b1);

        // Withdrawal with prio=0100 wraps to bit 0, then normal release to bit 1.
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);

        // Forced release after MAX_HOLD cycles.
        step(4'b0101, 1'b0, 1'b0);
        for (int i = 0; i < MAXH; i++) step(4'b0101, 1'b0, 1'b0);

        // Asynchronous reset while timeout is high and a grant is active.
        #1 rst_n = 1'b0;
        #1 check_reset_vals("async");
        #2 rst_n = 1'b1;
        model_reset();

        // Withdrawal of granted requester hands off on the next edge.
        step(4'b0110, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
